// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX stage and the
// iterative divider. The EX stage uses the master modport, the divider the slave.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 signed_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider, signed/unsigned, WIDTH+1 cycles.
// Result is {remainder, quotient}; the upper half feeds HI and the lower half LO.
// Optional macro DIV_FAST_EN: when |dividend| < |divisor| the accept edge jumps
// straight to END (quotient 0, remainder = dividend), skipping the iteration.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ZERO,
        S_ON,
        S_END
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;        // partial remainder
    logic [WIDTH-1:0]   r_quo;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_divisor;    // divisor magnitude
    logic [WIDTH-1:0]   r_op1_raw;    // untouched dividend, for the divide-by-zero result
    logic               r_q_neg;
    logic               r_r_neg;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_fast;
    logic               w_last;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    // Operand magnitudes; MIN negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign w_op1_neg  = bus.signed_i & bus.opdata1_i[WIDTH-1];
    assign w_op2_neg  = bus.signed_i & bus.opdata2_i[WIDTH-1];
    assign w_op1_mag  = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_op2_mag  = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    assign w_accept   = (r_state == S_IDLE) && bus.start_i && !bus.annul_i;
    assign w_div_zero = (bus.opdata2_i == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_FAST_EN
    assign w_fast = !w_div_zero && (w_op1_mag < w_op2_mag);
`else
    assign w_fast = 1'b0;
`endif

    // One restoring step: shift {rem, dividend} left, trial-subtract the divisor.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = !w_diff[WIDTH];
    assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

    // Sign fixup applied on the final step only.
    assign w_rem_fix  = r_r_neg ? -w_rem_step : w_rem_step;
    assign w_quo_fix  = r_q_neg ? -w_quo_step : w_quo_step;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; annul only matters while an operation is in flight.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_div_zero) begin
                        w_state_next = S_ZERO;
                    end else if (w_fast) begin
                        w_state_next = S_END;
                    end else begin
                        w_state_next = S_ON;
                    end
                end
            end
            S_ZERO: begin
                w_state_next = bus.annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                if (bus.annul_i) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_END;
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch on accept, iteration in ON, result capture on entry to END.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_op1_raw <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_op1_mag;
                        r_divisor <= w_op2_mag;
                        r_op1_raw <= bus.opdata1_i;
                        r_q_neg   <= w_op1_neg ^ w_op2_neg;
                        r_r_neg   <= w_op1_neg;
                        if (w_fast) begin
                            r_result <= {bus.opdata1_i, {WIDTH{1'b0}}};
                        end
                    end
                end
                S_ZERO: begin
                    if (!bus.annul_i) begin
                        r_result <= {r_op1_raw, {WIDTH{1'b1}}};
                    end
                end
                S_ON: begin
                    if (!bus.annul_i) begin
                        r_rem <= w_rem_step;
                        r_quo <= w_quo_step;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o   = (r_state == S_ON) || (r_state == S_ZERO);
    assign bus.ready_o  = (r_state == S_END);
    assign bus.result_o = (r_state == S_END) ? r_result : '0;

endmodule
